// File: rtl/tomasulo_pkg.sv
// Shared definitions for the issue front end: opcodes, issue classes, FSM states.
package tomasulo_pkg;

  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_I      = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    ARITH  = 2'd1,
    MEM    = 2'd2,
    OTHER  = 2'd3
  } issue_class_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2
  } issue_state_t;

  function automatic issue_class_t decode_class(input logic [6:0] opcode);
    issue_class_t cls;
    case (opcode)
      OP_R, OP_I:        cls = ARITH;
      OP_LOAD, OP_STORE: cls = MEM;
      default:           cls = OTHER;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with an extra pointer bit to tell full from empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_issue_unit.sv
// Issue stage: buffers instructions and presents the head to the core under stall back-pressure.
// state    | meaning
// ST_EMPTY | no instruction queued yet / queue drained
// ST_RUN   | queue holds instructions, issuing when unblocked
// ST_DONE  | last instruction issued; terminal until reset
module instr_issue_unit
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_instr,
  input  logic                    in_last,
  output logic [31:0]             instr,
  input  logic                    A_stall,
  input  logic                    LS_stall,
  output logic                    issued,
  output logic [1:0]              issue_class,
  output logic                    done,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [CNT_W-1:0]        issue_count,
  output logic [CNT_W-1:0]        stall_count
);

  issue_state_t state, state_next;
  issue_class_t cls;
  logic         full;
  logic         empty;
  logic [32:0]  head;
  logic         head_last;
  logic         push;
  logic         blocked;

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (issued),
    .din   ({in_last, in_instr}),
    .full  (full),
    .empty (empty),
    .count (occupancy),
    .head  (head)
  );

  assign done      = (state == ST_DONE);
  assign in_ready  = ~full & ~done;
  assign push      = in_valid & in_ready;
  assign head_last = head[32];

  always_comb begin
    cls = BUBBLE;
    if (!empty && !done) cls = decode_class(head[6:0]);
  end

  assign blocked     = ((cls == ARITH) & A_stall) | ((cls == MEM) & LS_stall);
  assign issued      = ~empty & ~blocked & ~done;
  assign instr       = (empty || done) ? NOP_INSTR : head[31:0];
  assign issue_class = cls;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: begin
        if (issued && head_last)  state_next = ST_DONE;
        else if (push || !empty)  state_next = ST_RUN;
      end
      ST_RUN: begin
        if (issued && head_last)  state_next = ST_DONE;
        else if (issued && !push && occupancy == 1) state_next = ST_EMPTY;
      end
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_EMPTY;
    endcase
  end

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_count <= '0;
      stall_count <= '0;
    end else begin
      if (issued && issue_count != '1)              issue_count <= issue_count + 1'b1;
      if (!empty && blocked && stall_count != '1)   stall_count <= stall_count + 1'b1;
    end
  end

endmodule
